// File: rtl/uart_pkg.sv
// Shared state encoding and constants for the UART transmit scheduler.
// Baud increments assume a 24 MHz clock and a 17-bit phase accumulator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS       = 8;
    localparam int BAUD_INC_460800 = 2520;
    localparam int BAUD_INC_115200 = 630;

endpackage

// File: rtl/uart_baud_tick.sv
// Phase-accumulator baud tick: one-cycle tick on accumulator carry-out, same cycle as the add.
// Latency: tick is combinational from the current accumulator; no backpressure.
module uart_baud_tick #(
    parameter int ACC_W = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             tick_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    // Carry of the widened sum marks each wrap, so fractional periods dither without drift.
    assign sum    = {1'b0, acc_q} + {1'b0, inc_i};
    assign tick_o = en_i & sum[ACC_W];

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART TX line between N_REQ byte sources.
// Latency: start bit begins the cycle after accept; frame_done pulses the cycle after the last stop bit.
// Backpressure: req_ready offered only in IDLE with nonzero baud_inc; sources hold valid until accepted.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ACC_W     = 17,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [ACC_W-1:0]         baud_inc,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     frame_done
);

    localparam int         ID_W      = $clog2(N_REQ);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e      state_q,    state_d;
    logic [7:0]       shift_q,    shift_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [ACC_W-1:0] inc_q,      inc_d;
    logic [ID_W-1:0]  grant_q,    grant_d;
    logic [ID_W-1:0]  ptr_q,      ptr_d;
    logic             done_q,     done_d;

    logic            arb_hit;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] cand;
    logic [7:0]      arb_byte;
    logic            accept;
    logic            tick;
    logic            tick_en;
    logic            tick_clr;

    // Search starts one past the last grant, so a continuously valid source waits its turn.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + 32'(k)) % 32'(N_REQ));
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && baud_inc != '0 && arb_hit) begin
            req_ready[arb_idx] = 1'b1;
        end
    end

    assign accept   = |req_ready;
    assign arb_byte = req_data[{arb_idx, 3'b000} +: 8];
    assign tick_en  = (state_q != IDLE);

    uart_baud_tick #(
        .ACC_W (ACC_W)
    ) u_baud_tick (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .inc_i  (inc_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        inc_d      = inc_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        done_d     = 1'b0;
        tick_clr   = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    shift_d  = arb_byte;
                    inc_d    = baud_inc;
                    grant_d  = arb_idx;
                    ptr_d    = arb_idx;
                    tick_clr = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            inc_q      <= '0;
            grant_q    <= '0;
            ptr_q      <= ID_W'(N_REQ - 1);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            inc_q      <= inc_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
        end
    end

    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-feature tasks check the line against a bit-period arithmetic model.
module tb_uart_tx_scheduler;

    localparam int N_REQ     = 4;
    localparam int ACC_W     = 17;
    localparam int STOP_BITS = 1;
    localparam int MAXC      = 2048;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic [ACC_W-1:0]     baud_inc;
    logic                 tx;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic             obs_ok;
    int               obs_wait;
    int               obs_idx;
    int               obs_done_at;
    int               obs_gid_bad;
    logic [N_REQ-1:0] obs_ready;
    logic             obs_tx   [0:MAXC];
    logic             obs_busy [0:MAXC];

    uart_tx_scheduler #(
        .N_REQ     (N_REQ),
        .ACC_W     (ACC_W),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .baud_inc   (baud_inc),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    // Cycle (counted from accept) on which the j-th bit boundary falls: ceil(j * 2^ACC_W / inc).
    function automatic int tick_at(int j, int inc);
        longint m;
        m = longint'(1) << ACC_W;
        return int'((longint'(j) * m + longint'(inc) - 1) / longint'(inc));
    endfunction

    function automatic int frame_len(int inc);
        return tick_at(1 + 8 + STOP_BITS, inc);
    endfunction

    function automatic logic model_tx(logic [7:0] b, int inc, int c);
        for (int j = 0; j < 1 + 8 + STOP_BITS; j++) begin
            if (c <= tick_at(j + 1, inc)) begin
                if (j == 0) return 1'b0;
                if (j <= 8) return b[j - 1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic int frame_errors(logic [7:0] b, int inc);
        int len;
        int e;
        len = frame_len(inc);
        e   = 0;
        if (obs_done_at != len + 1) return -1;
        for (int c = 1; c <= len; c++) begin
            if (obs_tx[c] !== model_tx(b, inc, c) || obs_busy[c] !== 1'b1) e++;
        end
        if (obs_tx[len + 1] !== 1'b1 || obs_busy[len + 1] !== 1'b0) e++;
        return e;
    endfunction

    function automatic int next_grant(int last, logic [N_REQ-1:0] mask);
        for (int k = 1; k <= N_REQ; k++) begin
            if (mask[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
    endtask

    // Waits for an accept, then records the line until frame_done; returns in the frame_done cycle.
    task automatic observe_frame(input int wait_budget, input bit drop, input int chg_at,
                                 input logic [ACC_W-1:0] chg_inc);
        obs_ok      = 1'b0;
        obs_wait    = 0;
        obs_idx     = -1;
        obs_done_at = 0;
        obs_gid_bad = 0;
        #1;
        while ((req_ready & req_valid) == '0 && obs_wait < wait_budget) begin
            @(negedge clk_in);
            #1;
            obs_wait++;
        end
        if ((req_ready & req_valid) == '0) return;
        obs_ready = req_ready;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && req_valid[i] && obs_idx < 0) obs_idx = i;
        end
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk_in);
            if (drop && c == 1) req_valid[obs_idx] = 1'b0;
            if (c == chg_at) baud_inc = chg_inc;
            #1;
            obs_tx[c]   = tx;
            obs_busy[c] = busy;
            if (int'(grant_id) != obs_idx) obs_gid_bad++;
            if (frame_done === 1'b1) begin
                obs_done_at = c;
                obs_ok      = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        baud_inc  = 17'd16384;
        @(negedge clk_in);
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
        @(negedge clk_in);
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_priority got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_byte();
        logic [9:0] got;
        logic [9:0] want;
        int         e;
        do_reset();
        baud_inc      = 17'd16384;
        req_data      = '0;
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        observe_frame(10, 1'b1, 0, '0);
        n_tests++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", obs_ready); end
        n_tests++; if (obs_done_at != 81) begin n_fail++; $display("FAIL single_done_cycle got %0d want 81", obs_done_at); end
        want = 10'b1101001010;
        got  = '0;
        for (int k = 0; k < 10; k++) got[k] = obs_tx[8 * k + 4];
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL single_bits got %b want %b", got, want); end
        e = frame_errors(8'hA5, 16384);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL single_waveform got %0d bad cycles want 0", e); end
        n_tests++; if (obs_gid_bad != 0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant got %0d want 0", grant_id); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_after got %b want 0000", req_ready); end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        baud_inc  = 17'd16384;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            observe_frame(10, 1'b0, 0, '0);
            n_tests++; if (!obs_ok || obs_idx != f % N_REQ) begin n_fail++; $display("FAIL rr_grant frame %0d got %0d want %0d", f, obs_idx, f % N_REQ); end
            e = frame_errors(8'h10 + 8'(f % N_REQ), 16384);
            n_tests++; if (e != 0) begin n_fail++; $display("FAIL rr_waveform frame %0d got %0d bad cycles want 0", f, e); end
            if (f > 0) begin
                n_tests++; if (obs_wait != 0) begin n_fail++; $display("FAIL rr_gap frame %0d got %0d extra idle cycles want 0", f, obs_wait); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_fairness();
        int want;
        int e;
        do_reset();
        baud_inc  = 17'd16384;
        req_data  = $urandom;
        req_valid = 4'b1000;
        observe_frame(10, 1'b0, 0, '0);
        n_tests++; if (obs_idx != 3) begin n_fail++; $display("FAIL fair_seed got %0d want 3", obs_idx); end
        req_valid = 4'b1010;
        for (int f = 0; f < 4; f++) begin
            want = (f % 2 == 0) ? 1 : 3;
            observe_frame(10, 1'b0, 0, '0);
            n_tests++; if (obs_idx != want) begin n_fail++; $display("FAIL fair_grant frame %0d got %0d want %0d", f, obs_idx, want); end
            e = frame_errors(req_data[8 * want +: 8], 16384);
            n_tests++; if (e != 0) begin n_fail++; $display("FAIL fair_waveform frame %0d got %0d bad cycles want 0", f, e); end
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int               last;
        int               want;
        int               inc;
        int               e;
        logic [N_REQ-1:0] mask;
        do_reset();
        last = N_REQ - 1;
        for (int f = 0; f < 6; f++) begin
            mask      = 4'($urandom_range(1, 15));
            inc       = int'($urandom_range(3000, 40000));
            req_valid = mask;
            req_data  = $urandom;
            baud_inc  = 17'(inc);
            want      = next_grant(last, mask);
            observe_frame(10, 1'b0, 0, '0);
            n_tests++; if (obs_idx != want) begin n_fail++; $display("FAIL rand_grant frame %0d mask %b got %0d want %0d", f, mask, obs_idx, want); end
            e = frame_errors(req_data[8 * want +: 8], inc);
            n_tests++; if (e != 0) begin n_fail++; $display("FAIL rand_waveform frame %0d inc %0d got %0d bad cycles want 0", f, inc, e); end
            last = want;
        end
        req_valid = '0;
    endtask

    task automatic test_zero_inc();
        int bad;
        int e;
        do_reset();
        baud_inc  = '0;
        req_data  = $urandom;
        req_valid = 4'b0100;
        bad = 0;
        repeat (20) begin
            @(negedge clk_in);
            #1;
            if (req_ready !== 4'b0000 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL zero_inc_hold got %0d bad cycles want 0", bad); end
        @(negedge clk_in);
        baud_inc = 17'd16384;
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL zero_inc_release got %b want 0100", req_ready); end
        observe_frame(0, 1'b1, 0, '0);
        n_tests++; if (obs_idx != 2) begin n_fail++; $display("FAIL zero_inc_grant got %0d want 2", obs_idx); end
        e = frame_errors(req_data[23:16], 16384);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL zero_inc_waveform got %0d bad cycles want 0", e); end
    endtask

    task automatic test_inc_change();
        int e;
        do_reset();
        baud_inc  = 17'd16384;
        req_data  = $urandom;
        req_valid = 4'b0010;
        observe_frame(10, 1'b0, 20, 17'd8192);
        e = frame_errors(req_data[15:8], 16384);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL inc_change_current got %0d bad cycles want 0", e); end
        observe_frame(10, 1'b1, 0, '0);
        n_tests++; if (obs_done_at != 161) begin n_fail++; $display("FAIL inc_change_next_len got %0d want 161", obs_done_at); end
        e = frame_errors(req_data[15:8], 8192);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL inc_change_next got %0d bad cycles want 0", e); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int e;
        int dones;
        do_reset();
        baud_inc  = 17'd16384;
        req_data  = $urandom;
        req_valid = 4'b0100;
        cnt = 0;
        #1;
        while (req_ready[2] !== 1'b1 && cnt < 10) begin
            @(negedge clk_in);
            #1;
            cnt++;
        end
        n_tests++; if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got %b want 0100", req_ready); end
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk_in);
            if (c == 1) req_valid = '0;
        end
        rst       = 1'b1;
        req_valid = 4'b0011;
        @(negedge clk_in);
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx got %b want 1", tx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready got %b want 0000", req_ready); end
        dones = (frame_done === 1'b1) ? 1 : 0;
        @(negedge clk_in);
        rst = 1'b0;
        #1;
        if (frame_done === 1'b1) dones++;
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rmid_no_done got %0d pulses want 0", dones); end
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_priority got %b want 0001", req_ready); end
        observe_frame(0, 1'b1, 0, '0);
        n_tests++; if (obs_idx != 0) begin n_fail++; $display("FAIL rmid_grant got %0d want 0", obs_idx); end
        req_valid = '0;
        e = frame_errors(req_data[7:0], 16384);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL rmid_waveform got %0d bad cycles want 0", e); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_fairness();
        test_random();
        test_zero_inc();
        test_inc_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 8N1 UART transmit line between N_REQ byte sources using round-robin arbitration.
- Sequences each frame from an internal phase-accumulator baud tick generator whose increment is runtime-configurable.
- Sits between on-chip byte producers and the board TX pin, clocked from the 24 MHz system clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ACC_W, 17, phase accumulator width.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk_in  input  1  system clock, 24 MHz.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  requester i byte at [8i+7:8i].
- req_ready  output  N_REQ  one-hot accept strobe.
- baud_inc  input  ACC_W  accumulator increment; 2520 gives 460800 baud at 24 MHz.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- grant_id  output  clog2(N_REQ)  index of current or last granted requester.
- frame_done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, frame_done=0, acc=0, state=IDLE. The round-robin pointer is set so requester 0 has highest priority.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first valid requester found searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready is all-zero when no requester is valid or when baud_inc==0.
  - Transfer occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
  - On transfer: latch the byte, latch baud_inc into inc_q, set grant_id=i, set the pointer to i, clear acc to 0, and go to START next cycle.
  - Requesters must not make valid depend on ready.
- Tick generation:
  - In every non-IDLE cycle, acc <= (acc + inc_q) mod 2^ACC_W.
  - tick is the carry out of the (ACC_W+1)-bit sum and is asserted combinationally in the same cycle.
- START: tx=0. On tick, go to DATA with bit_cnt=0.
- DATA: tx=shift[0], sent LSB first. On tick, shift right and increment bit_cnt. After the tick with bit_cnt==7, go to STOP.
- STOP: tx=1. Count STOP_BITS ticks; on the last one, go to IDLE and register frame_done=1 for exactly one cycle (the first IDLE cycle).
- busy=1 in START, DATA and STOP.
- Bit period: with inc_q dividing 2^ACC_W exactly, every bit lasts exactly 2^ACC_W/inc_q cycles. Otherwise, periods are dithered by ±1 cycle with no cumulative drift.
- baud_inc changes mid-frame have no effect until the next accept.
- Back-to-back frames:
  - A new accept is possible in the frame_done cycle, giving a minimum of 1 IDLE cycle between frames (tx=1).
  - A requester holding valid continuously is served again only after every other valid requester has been served once.
- No valid requester: remain in IDLE with tx=1; acc is frozen.
- Reset mid-frame: tx=1 at the next edge, the frame is aborted, no frame_done, and the latched byte is discarded.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - BAUD_INC_460800=2520 and BAUD_INC_115200=630 (24 MHz, ACC_W=17).
- Sub-module uart_baud_tick:
  - Contains the accumulator, enable and synchronous clear.
  - Outputs a single-cycle tick on carry out.
  - Replaces free-running MSB clock outputs with a tick usable in the clk_in domain.

Test Plan:
- Single byte: ACC_W=17, baud_inc=16384 (8 cycles/bit), req_valid[0] with 0xA5 → req_ready[0] pulses once. tx reads 0, 1,0,1,0,0,1,0,1, then 1, each held exactly 8 cycles, for an 80-cycle frame. frame_done pulses on cycle 81 after accept; grant_id=0.
- Round-robin: all four valid continuously, bytes 0x10..0x13 → grant order is 0,1,2,3,0 and each frame carries the matching byte. Gaps between frames are exactly 1 IDLE cycle.
- Fairness under contention: requesters 1 and 3 always valid, last grant 3 → next grants are 1,3,1,3 and requesters 0 and 2 are never granted.
- baud_inc=0 with req_valid[2]=1 → req_ready stays 0 and tx stays 1. Setting baud_inc=16384 → accept occurs the same cycle.
- baud_inc changed to 8192 mid-frame → the current frame keeps 8-cycle bits; the next frame uses 16-cycle bits.
- rst asserted during DATA bit 4 → the next cycle has tx=1, busy=0, req_ready=0 and no frame_done. After release with requesters 0 and 1 both valid, requester 0 is granted first.
